// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory read port, execute redirect and the
// valid/ready instruction stream towards decode.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    logic              instr_valid;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: halfword reads from instruction memory into a 2-entry
// FIFO feeding decode, with branch redirect that flushes and drains stale reads.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int unsigned DATA_W = 16;

    typedef enum logic {FETCH, DRAIN} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [1:0]        count_q, count_d;
    entry_t            head_q, head_d;
    entry_t            tail_q, tail_d;

    logic              transfer;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] target;
    entry_t            new_entry;

    // Next-state: redirect outranks everything, DRAIN swallows the stale ack.
    always_comb begin
        transfer   = req_q && bus.imem_ack;
        pop        = valid_q && bus.instr_ready;
        target     = bus.redirect_pc & ~ADDR_W'(1);
        new_entry  = '{instr: bus.imem_rdata, pc: fetch_pc_q};
        push       = 1'b0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (bus.redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = target;
            if (req_q && !bus.imem_ack) begin
                // Outstanding read cannot be withdrawn: keep req/addr, drop it on ack.
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = target;
            end
        end else if (state_q == DRAIN) begin
            if (bus.imem_ack) begin
                state_d = FETCH;
                req_d   = 1'b0;
                addr_d  = fetch_pc_q;
            end
        end else begin
            push = transfer;
            if (transfer) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(2);
            end
            count_d = count_q + 2'(push) - 2'(pop);

            if (pop) begin
                head_d = tail_q;
            end
            if (push) begin
                if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                    head_d = new_entry;
                end else begin
                    tail_d = new_entry;
                end
            end

            req_d  = (req_q && !bus.imem_ack) || (count_d != 2'd2);
            addr_d = fetch_pc_d;
        end

        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = head_q.instr;
    assign bus.instr_pc    = head_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, directed scenarios plus random traffic,
// checked against a program-order PC stream model via a scoreboard queue.
module tb_fetch_unit;
    localparam int unsigned ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a ^ 16'hC3A5) + {a[7:0], a[15:8]};
    endfunction

    // Memory responder: ack after cur_lat waiting cycles, data derived from address.
    int lat_min  = 0;
    int lat_max  = 0;
    int wait_cnt = 0;
    int cur_lat  = 0;

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wait_cnt     = 0;
                cur_lat      = lat_min;
                bus.imem_ack = 1'b0;
            end else if (bus.imem_req && wait_cnt >= cur_lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                wait_cnt       = 0;
                cur_lat        = int'($urandom_range(lat_max, lat_min));
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 16'($urandom);
                if (bus.imem_req) wait_cnt++;
            end
        end
    end

    // Scoreboard: expected stream is sequential PCs, restarted by reset or redirect.
    logic [15:0] exp_q[$];
    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic        prev_reset = 1'b1;
    logic [15:0] prev_addr  = 16'h0;

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                prev_reset = 1'b1;
                prev_req   = 1'b0;
                continue;
            end
            if (prev_req && !prev_ack && !prev_reset) begin
                check("req_held", bus.imem_req, 1'b1);
                check("addr_stable", bus.imem_addr, prev_addr);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", bus.instr_pc, e);
                    check("instr", bus.instr, mem_word(e));
                    exp_q.push_back(16'(e + 16'd2));
                end
            end
            if (bus.redirect) begin
                exp_q.delete();
                exp_q.push_back(bus.redirect_pc & 16'hFFFE);
            end
            prev_req   = bus.imem_req;
            prev_ack   = bus.imem_ack;
            prev_addr  = bus.imem_addr;
            prev_reset = 1'b0;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int lmin, input int lmax, input logic rdy);
        lat_min         = lmin;
        lat_max         = lmax;
        reset           = 1'b1;
        bus.instr_ready = rdy;
        bus.redirect    = 1'b0;
        cyc();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic found;
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0;
        bus.instr_ready = 1'b0;

        // Reset values, then zero-wait streaming with decode always ready.
        lat_min = 0; lat_max = 0;
        bus.instr_ready = 1'b1;
        cyc(); cyc(); cyc();
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_valid", bus.instr_valid, 1'b0);
        check("rst_instr", bus.instr, 16'h0);
        check("rst_instr_pc", bus.instr_pc, 16'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("t1_req", bus.imem_req, 1'b1);
            if (i < 4) check("t1_addr", bus.imem_addr, 16'(2 * i));
            if (i > 0) check("t1_valid", bus.instr_valid, 1'b1);
        end

        // Decode stalled five cycles: FIFO fills to two and fetch stops.
        do_reset(0, 0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i <= 2) check("t2_addr", bus.imem_addr, 16'(2 * (i - 1)));
            if (i >= 3) begin
                check("t2_req_low", bus.imem_req, 1'b0);
                check("t2_valid", bus.instr_valid, 1'b1);
                check("t2_pc_hold", bus.instr_pc, 16'h0000);
                check("t2_instr_hold", bus.instr, mem_word(16'h0000));
            end
        end
        cyc();
        bus.instr_ready = 1'b1;
        check("t2_req_still_low", bus.imem_req, 1'b0);
        cyc();
        check("t2_resume_req", bus.imem_req, 1'b1);
        check("t2_resume_addr", bus.imem_addr, 16'h0004);
        check("t2_second_pc", bus.instr_pc, 16'h0002);

        // Redirect coinciding with a zero-wait transfer and a pop, FIFO holding one.
        cyc(); cyc(); cyc();
        check("t4_pre", {bus.imem_req, bus.imem_ack, bus.instr_valid}, 3'b111);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        cyc();
        bus.redirect = 1'b0;
        check("t4_valid_flushed", bus.instr_valid, 1'b0);
        check("t4_req", bus.imem_req, 1'b1);
        check("t4_addr", bus.imem_addr, 16'h0100);
        cyc();
        check("t4_first_valid", bus.instr_valid, 1'b1);
        check("t4_first_pc", bus.instr_pc, 16'h0100);

        // Address wrap at the top of the space; bit 0 of the target ignored.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        cyc();
        bus.redirect = 1'b0;
        cyc();
        check("t5_pc_top", bus.instr_pc, 16'hFFFE);
        cyc();
        check("t5_pc_wrap", bus.instr_pc, 16'h0000);

        // Slow memory: redirect while the read at 0x0010 is outstanding.
        do_reset(3, 3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if (bus.imem_req && bus.imem_addr == 16'h0010) found = 1'b1;
        end
        check("t3_reach_0010", found, 1'b1);
        cyc();
        check("t3_pre_no_ack", bus.imem_ack, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0041;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            bus.redirect = 1'b0;
            check("t3_drain_req", bus.imem_req, 1'b1);
            check("t3_drain_addr", bus.imem_addr, 16'h0010);
            if (bus.imem_ack) found = 1'b1;
        end
        check("t3_stale_ack", found, 1'b1);
        cyc();
        check("t3_gap_req", bus.imem_req, 1'b0);
        cyc();
        check("t3_target_req", bus.imem_req, 1'b1);
        check("t3_target_addr", bus.imem_addr, 16'h0040);

        // Reset while draining with the stale ack still pending.
        check("t6_pre", {bus.imem_req, bus.imem_ack}, 2'b10);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0200;
        cyc();
        bus.redirect = 1'b0;
        check("t6_drain_pending", {bus.imem_req, bus.imem_ack}, 2'b10);
        reset = 1'b1;
        cyc();
        check("t6_req_low", bus.imem_req, 1'b0);
        check("t6_valid_low", bus.instr_valid, 1'b0);
        reset = 1'b0;
        cyc();
        check("t6_first_req", bus.imem_req, 1'b1);
        check("t6_first_addr", bus.imem_addr, RESET_PC);

        // Random latency, backpressure and redirects.
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            bus.instr_ready = ($urandom_range(99) < 70);
            bus.redirect    = ($urandom_range(99) < 4);
            bus.redirect_pc = 16'($urandom);
        end
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
